// File: rtl/dti_fifo_async_rd_prefetch_if.sv
// Read-side bundle of the async FIFO: pointer exchange, memory read port and output stream.
// The block uses the master modport; the environment (memory, synchroniser, consumer) uses the slave modport.
interface dti_fifo_async_rd_prefetch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_empty;
  logic [ADDR_WIDTH+1:0] rd_level;

  modport master (
    input  wr_ptr_gray_sync, mem_rd_data, rd_ready,
    output mem_rd_addr, rd_ptr_gray, rd_data, rd_valid, rd_empty, rd_level
  );

  modport slave (
    output wr_ptr_gray_sync, mem_rd_data, rd_ready,
    input  mem_rd_addr, rd_ptr_gray, rd_data, rd_valid, rd_empty, rd_level
  );
endinterface

// File: rtl/dti_fifo_async_rd_prefetch.sv
// Read side of a Gray-pointer async FIFO with a one-word prefetch output register.
// Memory is read combinationally at the read pointer; the output register refills whenever it drains.
module dti_fifo_async_rd_prefetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic rd_clk,
  input  logic rd_reset,
  dti_fifo_async_rd_prefetch_if.master bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         rd_bin_reg;
  logic [PW-1:0]         rd_bin_next;
  logic [PW-1:0]         rd_ptr_gray_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;
  logic                  rd_valid_next;
  logic [PW:0]           rd_level_reg;
  logic [PW:0]           rd_level_next;
  logic [PW-1:0]         wr_bin;
  logic [PW-1:0]         occupancy;
  logic                  mem_empty;
  logic                  fetch;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  assign wr_bin[PW-1] = bus.wr_ptr_gray_sync[PW-1];
  generate
    for (genvar gi = PW - 2; gi >= 0; gi--) begin : g_wr_bin
      assign wr_bin[gi] = wr_bin[gi+1] ^ bus.wr_ptr_gray_sync[gi];
    end
  endgenerate

  assign mem_empty = (rd_ptr_gray_reg == bus.wr_ptr_gray_sync);
  assign fetch     = !mem_empty && (!rd_valid_reg || bus.rd_ready);

  always_comb begin
    rd_bin_next   = rd_bin_reg;
    rd_valid_next = rd_valid_reg;
    if (fetch) begin
      rd_bin_next   = rd_bin_reg + 1'b1;
      rd_valid_next = 1'b1;
    end else if (rd_valid_reg && bus.rd_ready) begin
      rd_valid_next = 1'b0;
    end
  end

  // Level reflects the pointer and output register as they will be after this edge.
  assign occupancy     = wr_bin - rd_bin_next;
  assign rd_level_next = {1'b0, occupancy} + {{PW{1'b0}}, rd_valid_next};

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      rd_bin_reg      <= '0;
      rd_ptr_gray_reg <= '0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
      rd_level_reg    <= '0;
    end else begin
      rd_bin_reg      <= rd_bin_next;
      rd_ptr_gray_reg <= rd_bin_next ^ (rd_bin_next >> 1);
      rd_valid_reg    <= rd_valid_next;
      rd_level_reg    <= rd_level_next;
      if (fetch) begin
        rd_data_reg <= bus.mem_rd_data;
      end
    end
  end

  assign bus.mem_rd_addr = rd_bin_reg[ADDR_WIDTH-1:0];
  assign bus.rd_ptr_gray = rd_ptr_gray_reg;
  assign bus.rd_data     = rd_data_reg;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.rd_empty    = mem_empty && !rd_valid_reg;
  assign bus.rd_level    = rd_level_reg;
endmodule

// File: tb/tb_dti_fifo_async_rd_prefetch.sv
// Directed bench for the async FIFO read/prefetch side, with a combinational memory model.
module tb_dti_fifo_async_rd_prefetch;
  logic rd_clk;
  logic rd_reset;
  logic [7:0] mem [16];
  int total;
  int bad;

  dti_fifo_async_rd_prefetch_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  dti_fifo_async_rd_prefetch #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .rd_clk  (rd_clk),
    .rd_reset(rd_reset),
    .bus     (bus)
  );

  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_reset = 1'b1;
    bus.wr_ptr_gray_sync = '0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rd_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rd_reset = 1'b1;
    bus.wr_ptr_gray_sync = '0;
    bus.rd_ready = 1'b0;
    tick();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid_during: got=%b want=0", bus.rd_valid);
    end
    rd_reset = 1'b0;
    tick();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got=%b want=0", bus.rd_valid);
    end
    total++;
    if (bus.rd_empty !== 1'b1) begin
      bad++; $display("FAIL reset_empty: got=%b want=1", bus.rd_empty);
    end
    total++;
    if (bus.rd_level !== 6'd0) begin
      bad++; $display("FAIL reset_level: got=%0d want=0", bus.rd_level);
    end
    total++;
    if (bus.mem_rd_addr !== 4'd0) begin
      bad++; $display("FAIL reset_addr: got=%0d want=0", bus.mem_rd_addr);
    end
    total++;
    if (bus.rd_ptr_gray !== 5'd0 || bus.rd_data !== 8'h00) begin
      bad++; $display("FAIL reset_gray_data: got gray=%h data=%h want 0/00", bus.rd_ptr_gray, bus.rd_data);
    end
    $display("reset: valid=%b empty=%b level=%0d", bus.rd_valid, bus.rd_empty, bus.rd_level);
  endtask

  task automatic test_single_hold();
    do_reset();
    mem[0] = 8'hA5;
    bus.rd_ready = 1'b0;
    bus.wr_ptr_gray_sync = gray5(1);
    #1;
    total++;
    if (bus.rd_empty !== 1'b0) begin
      bad++; $display("FAIL single_empty_comb: got=%b want=0", bus.rd_empty);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin
      bad++; $display("FAIL single_fetch: got valid=%b data=%h want 1/a5", bus.rd_valid, bus.rd_data);
    end
    total++;
    if (bus.rd_ptr_gray !== 5'd1 || bus.rd_level !== 6'd1) begin
      bad++; $display("FAIL single_ptr_level: got gray=%h level=%0d want 1/1", bus.rd_ptr_gray, bus.rd_level);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5 || bus.rd_ptr_gray !== 5'd1 || bus.rd_level !== 6'd1) begin
        bad++; $display("FAIL single_hold[%0d]: got valid=%b data=%h gray=%h level=%0d want 1/a5/1/1",
                        i, bus.rd_valid, bus.rd_data, bus.rd_ptr_gray, bus.rd_level);
      end
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_empty !== 1'b1 || bus.rd_data !== 8'hA5 || bus.rd_level !== 6'd0) begin
      bad++; $display("FAIL single_pop: got valid=%b empty=%b data=%h level=%0d want 0/1/a5/0",
                      bus.rd_valid, bus.rd_empty, bus.rd_data, bus.rd_level);
    end
    $display("single: popped a5, valid=%b", bus.rd_valid);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data;
    logic [5:0] exp_level;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_data = 8'h10 + 8'(i);
      mem[i] = exp_data;
    end
    bus.wr_ptr_gray_sync = gray5(4);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_data  = 8'h10 + 8'(i);
      exp_level = 6'd4 - 6'(i);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data || bus.rd_level !== exp_level) begin
        bad++; $display("FAIL b2b_word[%0d]: got valid=%b data=%h level=%0d want 1/%h/%0d",
                        i, bus.rd_valid, bus.rd_data, bus.rd_level, exp_data, exp_level);
      end
      $display("b2b: word %0d data=%h level=%0d", i, bus.rd_data, bus.rd_level);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_empty !== 1'b1 || bus.rd_level !== 6'd0) begin
      bad++; $display("FAIL b2b_drained: got valid=%b empty=%b level=%0d want 0/1/0",
                      bus.rd_valid, bus.rd_empty, bus.rd_level);
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] exp_data;
    logic [5:0] exp_level;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_data = 8'h20 + 8'(i);
      mem[i] = exp_data;
    end
    bus.rd_ready = 1'b0;
    bus.wr_ptr_gray_sync = gray5(16);
    #1;
    total++;
    if (bus.rd_empty !== 1'b0 || bus.rd_level !== 6'd0) begin
      bad++; $display("FAIL full_pre_edge: got empty=%b level=%0d want 0/0", bus.rd_empty, bus.rd_level);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h20 || bus.rd_level !== 6'd16) begin
        bad++; $display("FAIL full_first[%0d]: got valid=%b data=%h level=%0d want 1/20/16",
                        i, bus.rd_valid, bus.rd_data, bus.rd_level);
      end
    end
    bus.rd_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick();
      exp_data  = 8'h20 + 8'(k);
      exp_level = 6'd16 - 6'(k);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data || bus.rd_level !== exp_level) begin
        bad++; $display("FAIL full_drain[%0d]: got valid=%b data=%h level=%0d want 1/%h/%0d",
                        k, bus.rd_valid, bus.rd_data, bus.rd_level, exp_data, exp_level);
      end
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_level !== 6'd0 || bus.rd_ptr_gray !== gray5(16)) begin
      bad++; $display("FAIL full_end: got valid=%b level=%0d gray=%h want 0/0/%h",
                      bus.rd_valid, bus.rd_level, bus.rd_ptr_gray, gray5(16));
    end
    $display("full: drained 16 words, gray=%h", bus.rd_ptr_gray);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_data;
    bus.rd_ready = 1'b1;
    bus.wr_ptr_gray_sync = gray5(31);
    for (int j = 1; j <= 15; j++) begin
      tick();
      exp_data = 8'h20 + 8'(j - 1);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin
        bad++; $display("FAIL wrap_lead[%0d]: got valid=%b data=%h want 1/%h", j, bus.rd_valid, bus.rd_data, exp_data);
      end
    end
    tick();
    bus.rd_ready = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_ptr_gray !== gray5(31) || bus.mem_rd_addr !== 4'd15) begin
      bad++; $display("FAIL wrap_at31: got valid=%b gray=%h addr=%0d want 0/%h/15",
                      bus.rd_valid, bus.rd_ptr_gray, bus.mem_rd_addr, gray5(31));
    end
    mem[15] = 8'h5C;
    bus.wr_ptr_gray_sync = gray5(32);
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5C) begin
      bad++; $display("FAIL wrap_fetch: got valid=%b data=%h want 1/5c", bus.rd_valid, bus.rd_data);
    end
    total++;
    if (bus.rd_ptr_gray !== 5'd0 || bus.mem_rd_addr !== 4'd0 || bus.rd_level !== 6'd1) begin
      bad++; $display("FAIL wrap_ptr: got gray=%h addr=%0d level=%0d want 0/0/1",
                      bus.rd_ptr_gray, bus.mem_rd_addr, bus.rd_level);
    end
    $display("wrap: fetched %h from address 15, gray=%h", bus.rd_data, bus.rd_ptr_gray);
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = 8'h77;
    bus.rd_ready = 1'b0;
    bus.wr_ptr_gray_sync = gray5(1);
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h77) begin
      bad++; $display("FAIL mid_setup: got valid=%b data=%h want 1/77", bus.rd_valid, bus.rd_data);
    end
    #2;
    rd_reset = 1'b1;
    bus.wr_ptr_gray_sync = '0;
    #1;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.rd_ptr_gray !== 5'd0 || bus.rd_level !== 6'd0) begin
      bad++; $display("FAIL mid_async_clear: got valid=%b data=%h gray=%h level=%0d want 0/00/0/0",
                      bus.rd_valid, bus.rd_data, bus.rd_ptr_gray, bus.rd_level);
    end
    tick();
    rd_reset = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_empty !== 1'b1 || bus.mem_rd_addr !== 4'd0) begin
      bad++; $display("FAIL mid_no_fetch: got valid=%b empty=%b addr=%0d want 0/1/0",
                      bus.rd_valid, bus.rd_empty, bus.mem_rd_addr);
    end
    bus.rd_ready = 1'b0;
    bus.wr_ptr_gray_sync = gray5(1);
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h77 || bus.rd_ptr_gray !== 5'd1) begin
      bad++; $display("FAIL mid_refetch: got valid=%b data=%h gray=%h want 1/77/1",
                      bus.rd_valid, bus.rd_data, bus.rd_ptr_gray);
    end
    $display("reset_mid: refetched %h", bus.rd_data);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rd_reset = 1'b1;
    bus.wr_ptr_gray_sync = '0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
